// File: rtl/upload_arbiter_if.sv
// upload_arbiter_if
//   Handshake and byte-stream bundle between the capture/measurement sources,
//   the packet arbiter and the USB CDC upload path.
//   Signals:
//     src_req[i]        source i has a packet pending
//     src_data[8i+7:8i] byte offered by source i
//     src_valid[i]      byte of source i is valid
//     src_last[i]       byte of source i is the last of its packet
//     src_ready[i]      byte of source i is accepted this cycle
//     upload_ready      USB side accepts the output byte this cycle
//     usb_upload_data   byte towards the USB upload path
//     usb_upload_valid  output byte is valid
//   Modports: slave = arbiter side, master = source/USB side.
interface upload_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   src_req;
    logic [8*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]   src_valid;
    logic [NUM_SRC-1:0]   src_last;
    logic [NUM_SRC-1:0]   src_ready;
    logic                 upload_ready;
    logic [7:0]           usb_upload_data;
    logic                 usb_upload_valid;

    modport slave (
        input  src_req, src_data, src_valid, src_last, upload_ready,
        output src_ready, usb_upload_data, usb_upload_valid
    );

    modport master (
        output src_req, src_data, src_valid, src_last, upload_ready,
        input  src_ready, usb_upload_data, usb_upload_valid
    );
endinterface

// File: rtl/upload_arbiter.sv
// upload_arbiter
//   Packet-level round-robin arbiter sharing the USB CDC upload byte stream
//   between several capture/measurement sources (PHY_CLK domain). Each granted
//   packet is prefixed with a header byte HDR_BASE | grant_id, then the
//   source's bytes pass straight through until its last byte. A stall timeout
//   forcibly releases a grant so a hung source cannot block the uplink.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     bus            upload_arbiter_if.slave (source handshakes + USB stream)
//     grant_id       index of the current or most recent grantee
//     busy           high while a packet (header or data) is in flight
//     timeout_pulse  one-cycle pulse on a forced release
module upload_arbiter #(
    parameter int         NUM_SRC  = 4,
    parameter int         TIMEOUT  = 1024,
    parameter logic [7:0] HDR_BASE = 8'hA0
) (
    input  logic            clk,
    input  logic            rst_n,
    upload_arbiter_if.slave bus,
    output logic [2:0]      grant_id,
    output logic            busy,
    output logic            timeout_pulse
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_DATA
    } state_t;

    state_t           state;
    logic [2:0]       rr_ptr;
    logic [2:0]       next_ptr;
    logic [2:0]       pick_idx;
    logic             pick_found;
    logic [CNT_W-1:0] stall_cnt;
    logic             xfer;
    logic             out_valid;
    logic [7:0]       out_data;

    // Per-source vectors widened to the 3-bit index space so grant_id can
    // index them directly for any NUM_SRC in 2..8.
    logic [7:0]       req_ext;
    logic [7:0]       valid_ext;
    logic [7:0]       last_ext;
    logic [7:0]       ready_ext;
    logic [63:0]      data_ext;

    assign req_ext   = 8'(bus.src_req);
    assign valid_ext = 8'(bus.src_valid);
    assign last_ext  = 8'(bus.src_last);
    assign data_ext  = 64'(bus.src_data);

    function automatic logic [2:0] wrap_idx(logic [2:0] base, int unsigned off);
        return 3'((32'(base) + off) % 32'(NUM_SRC));
    endfunction

    // First requester at or above rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!pick_found && req_ext[wrap_idx(rr_ptr, i)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_idx(rr_ptr, i);
            end
        end
    end

    assign next_ptr = (grant_id == 3'(NUM_SRC - 1)) ? '0 : grant_id + 3'd1;
    assign xfer     = (state == S_DATA) && valid_ext[grant_id] && bus.upload_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            grant_id      <= '0;
            stall_cnt     <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (bus.upload_ready) begin
                        state     <= S_DATA;
                        stall_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (last_ext[grant_id]) begin
                            state  <= S_IDLE;
                            rr_ptr <= next_ptr;
                        end
                    end else if (stall_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Forced release; a last byte on this same cycle
                        // would have taken the branch above instead.
                        state         <= S_IDLE;
                        rr_ptr        <= next_ptr;
                        stall_cnt     <= '0;
                        timeout_pulse <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Combinational output mux: data path is a zero-latency pass-through and
    // the output byte is forced to 0 whenever it is not valid.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        ready_ext = '0;
        case (state)
            S_HEADER: begin
                out_valid = 1'b1;
                out_data  = HDR_BASE | {5'b0, grant_id};
            end
            S_DATA: begin
                out_valid           = valid_ext[grant_id];
                out_data            = valid_ext[grant_id] ? data_ext[{grant_id, 3'b000} +: 8] : 8'h00;
                ready_ext[grant_id] = bus.upload_ready;
            end
            default: ;
        endcase
    end

    assign bus.usb_upload_valid = out_valid;
    assign bus.usb_upload_data  = out_data;
    assign bus.src_ready        = ready_ext[NUM_SRC-1:0];
    assign busy                 = (state != S_IDLE);

endmodule

// File: tb/tb_upload_arbiter.sv
// tb_upload_arbiter
//   Randomized bench for upload_arbiter with a packet-level reference model:
//   sources hold queues of packets, the model tracks who owns the uplink and
//   how many consecutive stall cycles have elapsed, and every cycle the DUT
//   outputs are compared against it. Directed scenarios add literal checks on
//   the observed upload stream.
module tb_upload_arbiter;

    localparam int NS = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] gid;
    logic       busy;
    logic       tp;

    upload_arbiter_if #(.NUM_SRC(NS)) ifc ();

    upload_arbiter #(
        .NUM_SRC (NS),
        .TIMEOUT (TO),
        .HDR_BASE(8'hA0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (ifc),
        .grant_id     (gid),
        .busy         (busy),
        .timeout_pulse(tp)
    );

    always #5 clk = ~clk;

    // source packet store
    logic [7:0] sbytes[NS][$];
    int         slens[NS][$];
    int         shpos[NS][$];
    int         shlen[NS][$];

    // reference model
    int owner = -1;
    bit in_hdr;
    int stall_run;
    int start_at;
    int last_gid;
    int cur_left;
    int cur_pos;
    int hpos;
    int stall_left;
    bit pulse_due;

    // driven inputs
    logic [NS-1:0]   req_d;
    logic [NS-1:0]   valid_d;
    logic [NS-1:0]   last_d;
    logic [8*NS-1:0] data_d;
    logic            ur;
    int              ur_mode;
    int              vmode;

    int cyc;
    int ncmp;
    int errs;
    logic [7:0] log_b[$];
    int         log_c[$];
    int         pulse_cnt;
    int         pulse_cyc;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_pkt(int s, int len, int hp, int hl, bit use_lit, logic [31:0] lit);
        for (int k = 0; k < len; k++)
            sbytes[s].push_back(use_lit ? lit[8*k +: 8] : 8'($urandom));
        slens[s].push_back(len);
        shpos[s].push_back(hp);
        shlen[s].push_back(hl);
    endtask

    task automatic release_owner(bit to);
        repeat (cur_left) void'(sbytes[owner].pop_front());
        void'(slens[owner].pop_front());
        void'(shpos[owner].pop_front());
        void'(shlen[owner].pop_front());
        start_at  = (owner + 1) % NS;
        owner     = -1;
        in_hdr    = 1'b0;
        pulse_due = to;
    endtask

    task automatic drive();
        ur = (ur_mode == 1) ? 1'b1 : (ur_mode == 2) ? 1'b0 : ($urandom_range(0, 9) < 7);
        for (int i = 0; i < NS; i++) begin
            req_d[i]         = (slens[i].size() > 0);
            valid_d[i]       = 1'($urandom_range(0, 1));
            data_d[8*i +: 8] = 8'($urandom);
            last_d[i]        = 1'($urandom_range(0, 1));
            if (i == owner && !in_hdr) begin
                req_d[i] = 1'($urandom_range(0, 1));
                if (cur_pos == hpos && stall_left > 0) valid_d[i] = 1'b0;
                else valid_d[i] = (vmode == 1) ? 1'b1 : ($urandom_range(0, 9) < 8);
                if (valid_d[i]) begin
                    data_d[8*i +: 8] = sbytes[i][0];
                    last_d[i]        = (cur_left == 1);
                end
            end
        end
        ifc.upload_ready = ur;
        ifc.src_req      = req_d;
        ifc.src_valid    = valid_d;
        ifc.src_last     = last_d;
        ifc.src_data     = data_d;
    endtask

    task automatic compare();
        logic          e_valid;
        logic [7:0]    e_data;
        logic [NS-1:0] e_ready;
        e_valid = 1'b0;
        e_data  = 8'h00;
        e_ready = '0;
        if (owner >= 0 && in_hdr) begin
            e_valid = 1'b1;
            e_data  = 8'hA0 + 8'(owner);
        end else if (owner >= 0) begin
            e_valid        = valid_d[owner];
            e_data         = e_valid ? sbytes[owner][0] : 8'h00;
            e_ready[owner] = ur;
        end
        chk("usb_upload_valid", 32'(ifc.usb_upload_valid), 32'(e_valid));
        chk("usb_upload_data", 32'(ifc.usb_upload_data), 32'(e_data));
        chk("src_ready", 32'(ifc.src_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("grant_id", 32'(gid), 32'(last_gid));
        chk("timeout_pulse", 32'(tp), 32'(pulse_due));
        if (ifc.usb_upload_valid && ifc.upload_ready) begin
            log_b.push_back(ifc.usb_upload_data);
            log_c.push_back(cyc);
        end
        if (tp) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
    endtask

    task automatic model_step();
        pulse_due = 1'b0;
        if (owner < 0) begin
            int pick;
            pick = -1;
            for (int k = 0; k < NS; k++)
                if (pick < 0 && req_d[(start_at + k) % NS]) pick = (start_at + k) % NS;
            if (pick >= 0) begin
                owner      = pick;
                in_hdr     = 1'b1;
                last_gid   = pick;
                cur_left   = slens[pick][0];
                cur_pos    = 0;
                hpos       = shpos[pick][0];
                stall_left = shlen[pick][0];
            end
        end else if (in_hdr) begin
            if (ur) begin
                in_hdr    = 1'b0;
                stall_run = 0;
            end
        end else if (valid_d[owner] && ur) begin
            void'(sbytes[owner].pop_front());
            cur_left--;
            cur_pos++;
            stall_run = 0;
            if (cur_left == 0) release_owner(1'b0);
        end else begin
            if (cur_pos == hpos && stall_left > 0) stall_left--;
            stall_run++;
            if (stall_run == TO) release_owner(1'b1);
        end
    endtask

    // One clock: drive after the edge, check at the falling edge, then advance
    // the model to what the next rising edge must produce.
    task automatic cycle();
        cyc++;
        drive();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic clear_log();
        log_b.delete();
        log_c.delete();
        pulse_cnt = 0;
        pulse_cyc = -1;
    endtask

    task automatic do_reset(string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(ifc.usb_upload_valid), 32'd0);
        chk({tag, "_data"}, 32'(ifc.usb_upload_data), 32'd0);
        chk({tag, "_ready"}, 32'(ifc.src_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_gid"}, 32'(gid), 32'd0);
        chk({tag, "_pulse"}, 32'(tp), 32'd0);
        if (owner >= 0) release_owner(1'b0);
        start_at  = 0;
        last_gid  = 0;
        pulse_due = 1'b0;
        stall_run = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic chk_log(string name, int n, logic [31:0] exp);
        chk({name, "_count"}, 32'(log_b.size()), 32'(n));
        for (int k = 0; k < n && k < log_b.size(); k++)
            chk(name, 32'(log_b[k]), 32'(exp[8*k +: 8]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int len;
        ifc.src_req      = '0;
        ifc.src_valid    = '0;
        ifc.src_last     = '0;
        ifc.src_data     = '0;
        ifc.upload_ready = 1'b0;
        ur_mode = 1;
        vmode   = 1;
        @(posedge clk);
        #1;
        do_reset("reset");

        // basic packet: A2 11 22 33 on consecutive cycles
        add_pkt(2, 3, -1, 0, 1'b1, 32'h0033_2211);
        run(6);
        chk_log("basic", 4, 32'h3322_11A2);
        if (log_c.size() == 4) chk("basic_consecutive", 32'(log_c[3] - log_c[0]), 32'd3);
        chk("basic_gid", 32'(gid), 32'd2);
        chk("basic_busy_after", 32'(busy), 32'd0);

        // round robin with all sources requesting 1-byte packets
        do_reset("rst_rr");
        for (int i = 0; i < NS; i++) begin
            add_pkt(i, 1, -1, 0, 1'b0, 0);
            add_pkt(i, 1, -1, 0, 1'b0, 0);
        end
        run(26);
        chk("rr_count", 32'(log_b.size()), 32'd16);
        for (int k = 0; k < 5 && 2 * k < log_b.size(); k++)
            chk("rr_header", 32'(log_b[2*k]), 32'(8'hA0 + 8'(k % 4)));

        // backpressure in header and mid-packet
        do_reset("rst_bp");
        add_pkt(1, 3, -1, 0, 1'b1, 32'h00B3_B2B1);
        ur_mode = 2; run(6);
        ur_mode = 1; run(2);
        ur_mode = 2; run(5);
        ur_mode = 1; run(4);
        chk_log("backpressure", 4, 32'hB3B2_B1A1);

        // timeout: src 1 hangs after one byte, src 2 waiting
        do_reset("rst_to");
        add_pkt(1, 3, 1, 1000, 1'b1, 32'h00C3_C2C1);
        add_pkt(2, 1, -1, 0, 1'b1, 32'h0000_00D1);
        run(16);
        chk_log("timeout", 4, 32'hD1A2_C1A1);
        chk("timeout_pulses", 32'(pulse_cnt), 32'd1);
        if (log_c.size() >= 2) chk("timeout_delay", 32'(pulse_cyc - log_c[1]), 32'(TO + 1));

        // last byte on the threshold cycle wins over the timeout
        clear_log();
        add_pkt(3, 2, 1, TO - 1, 1'b1, 32'h0000_E2E1);
        run(13);
        chk_log("last_vs_to", 3, 32'h00E2_E1A3);
        chk("last_vs_to_pulses", 32'(pulse_cnt), 32'd0);
        if (log_c.size() == 3) chk("last_vs_to_gap", 32'(log_c[2] - log_c[1]), 32'(TO));

        // reset in the middle of a packet
        clear_log();
        add_pkt(2, 5, -1, 0, 1'b0, 0);
        run(4);
        add_pkt(3, 1, -1, 0, 1'b0, 0);
        add_pkt(1, 1, -1, 0, 1'b0, 0);
        do_reset("rst_mid");
        run(8);
        chk("rst_mid_first_hdr", log_b.size() > 0 ? 32'(log_b[0]) : 32'hFFFF, 32'hA1);
        chk("rst_mid_second_hdr", log_b.size() > 2 ? 32'(log_b[2]) : 32'hFFFF, 32'hA3);

        // randomized traffic
        ur_mode = 0;
        vmode   = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                s = $urandom_range(0, NS - 1);
                if (slens[s].size() < 3) begin
                    len = $urandom_range(1, 6);
                    if ($urandom_range(0, 5) == 0)
                        add_pkt(s, len, $urandom_range(0, len - 1), $urandom_range(1, 12), 1'b0, 0);
                    else
                        add_pkt(s, len, -1, 0, 1'b0, 0);
                end
            end
            if (n == 1500) do_reset("rst_rand");
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", cyc, errs);
        $finish;
    end

endmodule
